// File: rtl/wb_port_arbiter_if.sv
// Write-port bundle between the write-back stage, late-result producers and the arbiter.
// The master modport is the requesting side; the slave modport is the arbiter.
interface wb_port_arbiter_if #(
  parameter int XLEN       = 64,
  parameter int FIFO_DEPTH = 2
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            pipe_valid;
  logic [4:0]      pipe_reg;
  logic [XLEN-1:0] pipe_data;
  logic            pipe_stall;

  logic            late_valid;
  logic            late_ready;
  logic [4:0]      late_reg;
  logic [XLEN-1:0] late_data;

  logic [CW-1:0]   fifo_count;

  logic            write_enable;
  logic [4:0]      write_reg;
  logic [XLEN-1:0] write_data;

  modport master (
    output pipe_valid, pipe_reg, pipe_data,
    output late_valid, late_reg, late_data,
    input  pipe_stall, late_ready, fifo_count,
    input  write_enable, write_reg, write_data
  );

  modport slave (
    input  pipe_valid, pipe_reg, pipe_data,
    input  late_valid, late_reg, late_data,
    output pipe_stall, late_ready, fifo_count,
    output write_enable, write_reg, write_data
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back vs. buffered late results.
// Optional macro WB_ARB_HAZARD_EN: pipeline writes kill older buffered results to the same reg.
module wb_port_arbiter #(
  parameter int XLEN         = 64,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  wb_port_arbiter_if.slave   bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [4:0]      r_mem_reg  [FIFO_DEPTH];
  logic [XLEN-1:0] r_mem_data [FIFO_DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [SW-1:0]   r_starve;

  logic            r_write_enable;
  logic [4:0]      r_write_reg;
  logic [XLEN-1:0] r_write_data;

  logic            w_full;
  logic            w_nonempty;
  logic            w_push;
  logic            w_force;
  logic            w_grant_pipe;
  logic            w_grant_head;
  logic [4:0]      w_head_reg;
  logic [XLEN-1:0] w_head_data;
  logic            w_head_live;
  logic            w_pipe_nz;
  logic            w_head_nz;

  assign w_full     = (r_count == DEPTH_C);
  assign w_nonempty = (r_count != '0);
  assign w_push     = bus.late_valid && !w_full;

  // The pipeline wins every tie until the FIFO has lost STARVE_LIMIT times in a row.
  assign w_force      = bus.pipe_valid && w_nonempty && (r_starve == LIMIT_C);
  assign w_grant_pipe = bus.pipe_valid && !w_force;
  assign w_grant_head = w_nonempty && !w_grant_pipe;

  assign w_head_reg  = r_mem_reg[r_rd_ptr];
  assign w_head_data = r_mem_data[r_rd_ptr];
  assign w_pipe_nz   = (bus.pipe_reg != 5'd0);
  assign w_head_nz   = (w_head_reg != 5'd0);

`ifdef WB_ARB_HAZARD_EN
  logic [FIFO_DEPTH-1:0] r_kill;
  logic [FIFO_DEPTH-1:0] w_kill_hit;

  // An entry is live when its distance from the read pointer is below the count.
  for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_hit
    logic [PW-1:0] w_off;
    assign w_off = PW'(g) - r_rd_ptr;
    assign w_kill_hit[g] = w_grant_pipe && w_pipe_nz &&
                           ({1'b0, w_off} < r_count) &&
                           (r_mem_reg[g] == bus.pipe_reg);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_kill_hit[i]) r_kill[i] <= 1'b1;
    end
    if (w_push) r_kill[r_wr_ptr] <= 1'b0;
  end

  assign w_head_live = !r_kill[r_rd_ptr];
`else
  assign w_head_live = 1'b1;
`endif

  // NOTE: the entry storage has no reset; pointers and count alone decide which
  // slots hold valid data, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_reg[r_wr_ptr]  <= bus.late_reg;
      r_mem_data[r_wr_ptr] <= bus.late_data;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every read in this
  // block sees the pre-edge value, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
      r_starve       <= '0;
      r_write_enable <= 1'b0;
      r_write_reg    <= 5'd0;
      r_write_data   <= '0;
    end else begin
      if (w_push)       r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_grant_head) r_rd_ptr <= r_rd_ptr + PW'(1);

      case ({w_push, w_grant_head})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (w_grant_head || !w_nonempty) begin
        r_starve <= '0;
      end else if (bus.pipe_valid && (r_starve != LIMIT_C)) begin
        r_starve <= r_starve + SW'(1);
      end

      // x0 targets still consume their slot but never strobe or carry data.
      if (w_grant_pipe) begin
        r_write_enable <= w_pipe_nz;
        r_write_reg    <= bus.pipe_reg;
        r_write_data   <= w_pipe_nz ? bus.pipe_data : '0;
      end else if (w_grant_head) begin
        r_write_enable <= w_head_nz && w_head_live;
        r_write_reg    <= w_head_reg;
        r_write_data   <= w_head_nz ? w_head_data : '0;
      end else begin
        r_write_enable <= 1'b0;
        r_write_reg    <= 5'd0;
        r_write_data   <= '0;
      end
    end
  end

  assign bus.late_ready   = !w_full;
  assign bus.fifo_count   = r_count;
  assign bus.pipe_stall   = w_force;
  assign bus.write_enable = r_write_enable;
  assign bus.write_reg    = r_write_reg;
  assign bus.write_data   = r_write_data;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_wb_port_arbiter;
  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending late results and a loss counter.
  typedef struct {
    logic [4:0]  r;
    logic [63:0] d;
    bit          k;
  } ent_t;

  ent_t        q[$];
  int          starve = 0;
  logic        m_en;
  logic [4:0]  m_reg;
  logic [63:0] m_data;
  bit          cmp_en = 1'b0;

  always @(posedge clk) begin
    bit   ne;
    bit   force_h;
    bit   accept;
    ent_t e;
    if (reset) begin
      q.delete();
      starve = 0;
      m_en   = 1'b0;
      m_reg  = 5'd0;
      m_data = 64'd0;
    end else begin
      ne      = (q.size() > 0);
      accept  = bus.late_valid && (q.size() < DEPTH);
      force_h = bus.pipe_valid && ne && (starve >= LIMIT);
      if (bus.pipe_valid && !force_h) begin
        m_en   = (bus.pipe_reg != 0);
        m_reg  = bus.pipe_reg;
        m_data = m_en ? bus.pipe_data : 64'd0;
`ifdef WB_ARB_HAZARD_EN
        if (bus.pipe_reg != 0)
          foreach (q[i]) if (q[i].r == bus.pipe_reg) q[i].k = 1'b1;
`endif
        starve = ne ? ((starve + 1 > LIMIT) ? LIMIT : starve + 1) : 0;
      end else if (ne) begin
        e      = q.pop_front();
        m_en   = (e.r != 0) && !e.k;
        m_reg  = e.r;
        m_data = (e.r != 0) ? e.d : 64'd0;
        starve = 0;
      end else begin
        m_en   = 1'b0;
        m_reg  = 5'd0;
        m_data = 64'd0;
        starve = 0;
      end
      if (accept) begin
        e.r = bus.late_reg;
        e.d = bus.late_data;
        e.k = 1'b0;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("write_enable", 64'(bus.write_enable), 64'(m_en));
      check("write_reg",    64'(bus.write_reg),    64'(m_reg));
      check("write_data",   bus.write_data,        m_data);
      check("fifo_count",   64'(bus.fifo_count),   64'(q.size()));
      check("late_ready",   64'(bus.late_ready),   64'(q.size() < DEPTH));
      check("pipe_stall",   64'(bus.pipe_stall),
            64'(bus.pipe_valid && (q.size() > 0) && (starve >= LIMIT)));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_valid = 1'b0;
    bus.pipe_reg   = 5'd0;
    bus.pipe_data  = '0;
    bus.late_valid = 1'b0;
    bus.late_reg   = 5'd0;
    bus.late_data  = '0;
  endtask

  task automatic drive_pipe(input logic [4:0] r, input logic [63:0] d);
    bus.pipe_valid = 1'b1;
    bus.pipe_reg   = r;
    bus.pipe_data  = d;
  endtask

  task automatic drive_late(input logic [4:0] r, input logic [63:0] d);
    bus.late_valid = 1'b1;
    bus.late_reg   = r;
    bus.late_data  = d;
  endtask

  initial begin
    int n;
    idle();
    reset = 1'b1;
    step();
    step();
    cmp_en = 1'b1;
    reset  = 1'b0;
    check("rst fifo_count",   64'(bus.fifo_count),   0);
    check("rst write_enable", 64'(bus.write_enable), 0);
    check("rst write_data",   bus.write_data,        0);
    check("rst late_ready",   64'(bus.late_ready),   1);

    // Plain pipeline write
    drive_pipe(5'd5, 64'h11);
    #1 check("t1 pipe_stall", 64'(bus.pipe_stall), 0);
    step();
    check("t1 write_enable", 64'(bus.write_enable), 1);
    check("t1 write_reg",    64'(bus.write_reg),    5);
    check("t1 write_data",   bus.write_data,        64'h11);
    idle();

    // Late result with idle pipeline
    drive_late(5'd7, 64'hAA);
    step();
    bus.late_valid = 1'b0;
    check("t2 fifo_count=1",  64'(bus.fifo_count),   1);
    check("t2 no write yet",  64'(bus.write_enable), 0);
    step();
    check("t2 write_enable",  64'(bus.write_enable), 1);
    check("t2 write_reg",     64'(bus.write_reg),    7);
    check("t2 write_data",    bus.write_data,        64'hAA);
    check("t2 fifo_count=0",  64'(bus.fifo_count),   0);

    // Starvation bound: four pipeline wins, then a forced head grant
    drive_pipe(5'd1, 64'h100);
    drive_late(5'd9, 64'h99);
    step();
    bus.late_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive_pipe(5'(10 + k), 64'(256 + k));
      #1 check("t3 no stall", 64'(bus.pipe_stall), 0);
      step();
      check("t3 pipe write reg", 64'(bus.write_reg), 64'(10 + k));
    end
    drive_pipe(5'd15, 64'h105);
    #1 check("t3 forced stall", 64'(bus.pipe_stall), 1);
    step();
    check("t3 head write_reg",  64'(bus.write_reg),    9);
    check("t3 head write_data", bus.write_data,        64'h99);
    check("t3 head write_en",   64'(bus.write_enable), 1);
    #1 check("t3 stall released", 64'(bus.pipe_stall), 0);
    step();
    check("t3 resumed write_reg",  64'(bus.write_reg), 15);
    check("t3 resumed write_data", bus.write_data,     64'h105);
    idle();

    // Back-pressure while full; a pop in the same cycle does not free the slot
    drive_pipe(5'd20, 64'h200);
    drive_late(5'd21, 64'hA1);
    step();
    drive_late(5'd22, 64'hA2);
    step();
    drive_late(5'd23, 64'hA3);
    #1;
    check("t4 full late_ready", 64'(bus.late_ready), 0);
    check("t4 full count",      64'(bus.fifo_count), 2);
    n = 0;
    while (bus.fifo_count != 1 && n < 20) begin
      check("t4 refused while full", 64'(bus.late_ready), 0);
      step();
      n++;
    end
    check("t4 drain within bound", 64'(n < 20), 1);
    check("t4 ready after pop",    64'(bus.late_ready), 1);
    step();
    bus.late_valid = 1'b0;
    check("t4 third accepted", 64'(bus.fifo_count), 2);
    idle();
    n = 0;
    while (bus.fifo_count != 0 && n < 20) begin
      step();
      n++;
    end
    check("t4 empty within bound", 64'(n < 20), 1);

    // x0 from both sources
    drive_pipe(5'd0, 64'hFF);
    step();
    check("t5 pipe x0 write_enable", 64'(bus.write_enable), 0);
    check("t5 pipe x0 write_data",   bus.write_data,        0);
    idle();
    drive_late(5'd0, 64'h55);
    step();
    bus.late_valid = 1'b0;
    step();
    check("t5 late x0 write_enable", 64'(bus.write_enable), 0);
    check("t5 late x0 write_data",   bus.write_data,        0);
    check("t5 late x0 popped",       64'(bus.fifo_count),   0);

    // Same register from both sources
    drive_pipe(5'd4, 64'h44);
    drive_late(5'd3, 64'h1);
    step();
    bus.late_valid = 1'b0;
    drive_pipe(5'd3, 64'h2);
    step();
    check("t6 pipe write_reg",  64'(bus.write_reg), 3);
    check("t6 pipe write_data", bus.write_data,     64'h2);
    check("t6 entry waiting",   64'(bus.fifo_count), 1);
    idle();
    step();
`ifdef WB_ARB_HAZARD_EN
    check("t6 killed entry write_enable", 64'(bus.write_enable), 0);
`else
    check("t6 late write_enable", 64'(bus.write_enable), 1);
    check("t6 late write_data",   bus.write_data,        64'h1);
`endif
    check("t6 entry popped", 64'(bus.fifo_count), 0);
    drive_pipe(5'd6, 64'h66);
    drive_late(5'd6, 64'h67);
    step();
    idle();
    step();
    check("t6 same-cycle push survives", 64'(bus.write_enable), 1);
    check("t6 same-cycle push data",     bus.write_data,        64'h67);

    // Reset with a full FIFO discards buffered results
    drive_pipe(5'd8, 64'h80);
    drive_late(5'd10, 64'hB0);
    step();
    drive_late(5'd11, 64'hB1);
    step();
    check("t7 full before reset", 64'(bus.fifo_count), 2);
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t7 count cleared", 64'(bus.fifo_count),   0);
    check("t7 no write",      64'(bus.write_enable), 0);
    check("t7 late_ready",    64'(bus.late_ready),   1);
    for (int k = 0; k < 8; k++) begin
      step();
      check("t7 no buffered write", 64'(bus.write_enable), 0);
    end

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between two sources.
  - The in-order pipeline write-back stage.
  - Long-latency result producers (multi-cycle mul/div, miss-return loads) arriving out of band.
- Late results are buffered in a small FIFO.
- A fixed-priority arbiter favours the pipeline and bounds late-result starvation by stalling write-back.
- Sits between the write-back stage and the register file; drives write_enable/write_reg/write_data.

Parameters:
- XLEN, 64, data width of a register write.
- FIFO_DEPTH, 2, late-result buffer entries; power of two, >= 2.
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose arbitration before it is forced to win; >= 1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- pipe_valid  input  1  pipeline write-back request this cycle
- pipe_reg  input  5  pipeline destination register
- pipe_data  input  XLEN  pipeline write data
- pipe_stall  output  1  pipeline request not accepted this cycle; upstream holds pipe_* stable
- late_valid  input  1  late result offered
- late_ready  output  1  FIFO can accept a late result
- late_reg  input  5  late destination register
- late_data  input  XLEN  late write data
- fifo_count  output  $clog2(FIFO_DEPTH)+1  valid FIFO entries
- write_enable  output  1  register-file write strobe
- write_reg  output  5  register-file write index
- write_data  output  XLEN  register-file write data

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- On reset:
  - FIFO emptied; fifo_count=0.
  - starve_cnt=0.
  - write_enable=0, write_reg=0, write_data=0.
  - late_ready=1 in the first cycle after reset is released.
- Reset mid-operation: buffered late results are discarded, not written.
- late_ready = !full, from registered state only.
  - A full FIFO refuses a push even in a cycle that also pops.
- Push: occurs when late_valid && late_ready at clk.
  - A pushed entry becomes eligible for arbitration the following cycle; there is no same-cycle bypass.
- Arbitration, combinational each cycle; head = oldest valid FIFO entry:
  - pipe_valid only: pipeline granted.
  - FIFO non-empty only: head granted.
  - Both, starve_cnt < STARVE_LIMIT: pipeline granted; starve_cnt += 1.
  - Both, starve_cnt == STARVE_LIMIT: head granted; pipe_stall=1.
  - Whenever head is granted or the FIFO is empty, starve_cnt resets to 0.
- pipe_stall is 1 only in the forced-head case; otherwise 0, including when pipe_valid=0.
- Output register, one-cycle latency from grant to the write_* outputs:
  - write_reg and write_data take the granted source's values.
  - write_enable=1 iff a grant occurred and the granted reg != 0.
- x0 handling: a grant targeting x0 still consumes its slot (FIFO pop or pipeline acceptance) but produces write_enable=0 and write_data=0.
- No grant: write_enable=0; write_reg and write_data are driven to 0.
- Simultaneous push and pop (not full): fifo_count unchanged; ordering preserved.
- FIFO pointers wrap modulo FIFO_DEPTH.
- starve_cnt saturates at STARVE_LIMIT; it never wraps.

Optional Feature:
- Macro: WB_ARB_HAZARD_EN.
- Defined:
  - On each accepted pipeline write with pipe_reg != 0, every valid FIFO entry with the same reg is marked killed.
  - The pipeline write is younger and supersedes the entry.
  - A killed entry still pops in order when granted, with write_enable=0.
  - A push in the same cycle with the same reg is not killed.
- Undefined:
  - No comparison is made; ordering between sources is the upstream scoreboard's responsibility.
  - Every FIFO entry writes when granted.

Test Plan:
- Reset, then pipe_valid=1, pipe_reg=5, pipe_data=0x11 -> next cycle write_enable=1, write_reg=5, write_data=0x11, pipe_stall=0.
- late push reg=7, data=0xAA with pipe idle -> fifo_count=1 next cycle; the write of reg 7 / 0xAA appears one cycle later; fifo_count returns to 0.
- FIFO holds reg=9; pipe_valid held 1 continuously -> 4 pipeline writes, then a cycle with pipe_stall=1 and write reg 9; then the pipeline resumes.
- Push 2 late results with pipe busy -> late_ready=0; a third late_valid is not accepted until fifo_count drops to 1.
- pipe_reg=0, pipe_data=0xFF -> write_enable=0, write_data=0; late entry with reg 0 pops with write_enable=0.
- WB_ARB_HAZARD_EN defined: FIFO holds reg=3/0x1; pipeline writes reg=3/0x2 -> only the 0x2 write occurs; the entry pops with write_enable=0. Undefined: both writes occur, pipeline first. Also: assert reset with fifo_count=2 -> next cycle fifo_count=0, write_enable=0, and no buffered write ever appears.
